// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin share of one memory channel, one transaction in flight at a time.
// Optional watchdog with sticky timeout_err when MEM_ARB_WATCHDOG_EN is defined.
module mem_arbiter #(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
`ifdef MEM_ARB_WATCHDOG_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
    output logic                                    mem_read_valid,
    output logic [ADDR_BITS-1:0]                    mem_read_address,
    input  logic                                    mem_read_ready,
    input  logic [DATA_BITS-1:0]                    mem_read_data,
    output logic                                    mem_write_valid,
    output logic [ADDR_BITS-1:0]                    mem_write_address,
    output logic [DATA_BITS-1:0]                    mem_write_data,
    input  logic                                    mem_write_ready
`ifdef MEM_ARB_WATCHDOG_EN
    ,
    output logic                                    timeout_err
`endif
);
    localparam int PTR_W = $clog2(NUM_CONSUMERS);
    localparam logic [1:0] IDLE = 2'd0, READ_WAIT = 2'd1, WRITE_WAIT = 2'd2, RELAY = 2'd3;

    logic [1:0] state;
    logic [PTR_W-1:0] rr_ptr, owner, grant_idx;
    logic grant_found, is_write, relay_done, wd_fire;
    logic [NUM_CONSUMERS-1:0] req;

    function automatic logic [PTR_W-1:0] wrap(input int v);
        return PTR_W'(v % NUM_CONSUMERS);
    endfunction

    assign req = consumer_read_valid | consumer_write_valid;
    assign relay_done = is_write ? !consumer_write_valid[owner] : !consumer_read_valid[owner];

    // First requester at or after rr_ptr wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_CONSUMERS; k++)
            if (!grant_found && req[wrap(int'(rr_ptr) + k)]) begin
                grant_found = 1'b1;
                grant_idx = wrap(int'(rr_ptr) + k);
            end
    end

`ifdef MEM_ARB_WATCHDOG_EN
    localparam int WD_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [WD_W-1:0] wd_cnt;

    // A genuine memory response on the final cycle takes precedence over the timeout.
    assign wd_fire = wd_cnt == WD_W'(TIMEOUT_CYCLES - 1) &&
                     ((state == READ_WAIT && !mem_read_ready) || (state == WRITE_WAIT && !mem_write_ready));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt <= '0;
            timeout_err <= 1'b0;
        end else begin
            wd_cnt <= (state == READ_WAIT || state == WRITE_WAIT) ? wd_cnt + 1'b1 : '0;
            if (wd_fire)
                timeout_err <= 1'b1;
        end
    end
`else
    assign wd_fire = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            rr_ptr <= '0;
            owner <= '0;
            is_write <= 1'b0;
            mem_read_valid <= 1'b0;
            mem_read_address <= '0;
            mem_write_valid <= 1'b0;
            mem_write_address <= '0;
            mem_write_data <= '0;
            consumer_read_ready <= '0;
            consumer_write_ready <= '0;
            consumer_read_data <= '0;
        end else begin
            case (state)
                IDLE: if (grant_found) begin
                    owner <= grant_idx;
                    rr_ptr <= wrap(int'(grant_idx) + 1);
                    is_write <= !consumer_read_valid[grant_idx];
                    if (consumer_read_valid[grant_idx]) begin
                        mem_read_valid <= 1'b1;
                        mem_read_address <= consumer_read_address[grant_idx];
                        state <= READ_WAIT;
                    end else begin
                        mem_write_valid <= 1'b1;
                        mem_write_address <= consumer_write_address[grant_idx];
                        mem_write_data <= consumer_write_data[grant_idx];
                        state <= WRITE_WAIT;
                    end
                end
                READ_WAIT: if (mem_read_ready || wd_fire) begin
                    mem_read_valid <= 1'b0;
                    consumer_read_data[owner] <= wd_fire ? '0 : mem_read_data;
                    consumer_read_ready[owner] <= 1'b1;
                    state <= RELAY;
                end
                WRITE_WAIT: if (mem_write_ready || wd_fire) begin
                    mem_write_valid <= 1'b0;
                    consumer_write_ready[owner] <= 1'b1;
                    state <= RELAY;
                end
                default: if (relay_done) begin
                    consumer_read_ready <= '0;
                    consumer_write_ready <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [N-1:0] rv, wv, rr, wr;
    logic [N-1:0][7:0] ra, wa, wd, rd;
    logic mrv, mwv, mrr, mwr;
    logic [7:0] mra, mrd, mwa, mwd;
`ifdef MEM_ARB_WATCHDOG_EN
    logic timeout_err;
`endif

    int tests, fails;
    int rd_lat, wr_lat, rd_cnt, wr_cnt;
    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    int order[$];

    always #5 clk = ~clk;

    mem_arbiter #(
        .NUM_CONSUMERS(N), .ADDR_BITS(8), .DATA_BITS(8)
`ifdef MEM_ARB_WATCHDOG_EN
        , .TIMEOUT_CYCLES(8)
`endif
    ) dut (
        .clk(clk), .reset(reset),
        .consumer_read_valid(rv), .consumer_read_address(ra),
        .consumer_read_ready(rr), .consumer_read_data(rd),
        .consumer_write_valid(wv), .consumer_write_address(wa),
        .consumer_write_data(wd), .consumer_write_ready(wr),
        .mem_read_valid(mrv), .mem_read_address(mra),
        .mem_read_ready(mrr), .mem_read_data(mrd),
        .mem_write_valid(mwv), .mem_write_address(mwa),
        .mem_write_data(mwd), .mem_write_ready(mwr)
`ifdef MEM_ARB_WATCHDOG_EN
        , .timeout_err(timeout_err)
`endif
    );

    // One negedge step; the memory side answers after rd_lat/wr_lat cycles (negative: never).
    task automatic tick();
        @(negedge clk);
        if (mrr) mrr = 1'b0;
        else if (mrv) begin
            if (rd_lat >= 0 && rd_cnt >= rd_lat) begin
                mrr = 1'b1;
                mrd = mem[mra];
                rd_cnt = 0;
            end else rd_cnt++;
        end else rd_cnt = 0;
        if (mwr) mwr = 1'b0;
        else if (mwv) begin
            if (wr_lat >= 0 && wr_cnt >= wr_lat) begin
                mwr = 1'b1;
                mem[mwa] = mwd;
                wr_cnt = 0;
            end else wr_cnt++;
        end else wr_cnt = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rv = '0;
        wv = '0;
        mrr = 1'b0;
        mwr = 1'b0;
        rd_cnt = 0;
        wr_cnt = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_ready(input int c, input bit is_wr, output int n);
        n = 0;
        while (!(is_wr ? wr[c] : rr[c]) && n < 100) begin
            tick();
            n++;
        end
    endtask

    // Serve all pending requests, recording completion order (reads i, writes i+N).
    task automatic collect();
        order = {};
        for (int t = 0; t < 200 && (rv | wv) != 0; t++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (rr[i] && rv[i]) begin order.push_back(i); rv[i] = 1'b0; end
                if (wr[i] && wv[i]) begin order.push_back(i + N); wv[i] = 1'b0; end
            end
        end
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (mrv !== 1'b0 || mwv !== 1'b0) begin fails++; $display("FAIL reset_mem_valid: read=%b write=%b, expected 0 0", mrv, mwv); end
        tests++;
        if (rr !== '0 || wr !== '0) begin fails++; $display("FAIL reset_ready: read=%b write=%b, expected 0 0", rr, wr); end
        tests++;
        if (rd !== '0) begin fails++; $display("FAIL reset_read_data: got %h expected 0", rd); end
        tests++;
        if (mra !== 8'h0 || mwa !== 8'h0 || mwd !== 8'h0) begin fails++; $display("FAIL reset_mem_bus: %h %h %h expected 0", mra, mwa, mwd); end
`ifdef MEM_ARB_WATCHDOG_EN
        tests++;
        if (timeout_err !== 1'b0) begin fails++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
`endif
    endtask

    task automatic test_single_read();
        int n;
        bit ok;
        mem[8'h10] = 8'hA5;
        rd_lat = 1;
        ra[2] = 8'h10;
        rv[2] = 1'b1;
        wait_ready(2, 1'b0, n);
        tests++;
        if (n !== 3) begin fails++; $display("FAIL single_read_latency: ready after %0d negedges, expected 3", n); end
        tests++;
        if (rd[2] !== 8'hA5) begin fails++; $display("FAIL single_read_data: got %h expected a5", rd[2]); end
        tests++;
        if (rr !== 4'b0100) begin fails++; $display("FAIL single_read_ready: got %b expected 0100", rr); end
        rv[2] = 1'b0;
        tick();
        tests++;
        if (rr !== '0) begin fails++; $display("FAIL single_read_pulse: got %b expected 0000", rr); end
        tests++;
        if (rd[2] !== 8'hA5) begin fails++; $display("FAIL single_read_hold: got %h expected a5", rd[2]); end
        rd_lat = 0;
        ra[0] = 8'h01;
        ra[3] = 8'h03;
        rv = 4'b1001;
        collect();
        ok = order.size() == 2 && order[0] == 3 && order[1] == 0;
        tests++;
        if (!ok) begin fails++; $display("FAIL single_read_rr_next: %0d grants first=%0d, expected 3 then 0", order.size(), order[0]); end
    endtask

    task automatic test_contention();
        bit ok;
        do_reset();
        rd_lat = 0;
        for (int i = 0; i < N; i++) begin
            ra[i] = 8'(8'h20 + i);
            mem[8'h20 + i] = 8'(8'hC0 + i);
        end
        for (int r = 0; r < 2; r++) begin
            rv = '1;
            collect();
            ok = order.size() == N;
            for (int k = 0; k < order.size(); k++) if (order[k] != k) ok = 1'b0;
            tests++;
            if (!ok) begin fails++; $display("FAIL contention_order round %0d: %0d grants first=%0d, expected 0,1,2,3", r, order.size(), order[0]); end
        end
        ok = 1'b1;
        for (int i = 0; i < N; i++) if (rd[i] !== 8'(8'hC0 + i)) ok = 1'b0;
        tests++;
        if (!ok) begin fails++; $display("FAIL contention_data: got %h expected c3c2c1c0", rd); end
    endtask

    task automatic test_write();
        int n = 0, bad = 0, seen = 0;
        wr_lat = 2;
        mem[8'h7F] = 8'h00;
        wa[1] = 8'h7F;
        wd[1] = 8'h33;
        wv[1] = 1'b1;
        while (!wr[1] && n < 100) begin
            tick();
            n++;
            if (mwv) seen++;
            if (mwv && (mwa !== 8'h7F || mwd !== 8'h33)) bad++;
        end
        tests++;
        if (!wr[1] || seen == 0) begin fails++; $display("FAIL write_ready: ready=%b valid cycles=%0d, expected ready with valid seen", wr, seen); end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL write_bus: %0d cycles with addr/data not 7f/33", bad); end
        tests++;
        if (mem[8'h7F] !== 8'h33) begin fails++; $display("FAIL write_mem: got %h expected 33", mem[8'h7F]); end
        wv[1] = 1'b0;
        tick();
        tests++;
        if (wr !== '0 || mwv !== 1'b0) begin fails++; $display("FAIL write_pulse: ready=%b mem_valid=%b expected 0", wr, mwv); end
    endtask

    task automatic test_read_write_same();
        rd_lat = 1;
        wr_lat = 1;
        mem[8'h40] = 8'h5A;
        ra[0] = 8'h40;
        wa[0] = 8'h41;
        wd[0] = 8'h99;
        rv[0] = 1'b1;
        wv[0] = 1'b1;
        collect();
        tests++;
        if (order.size() != 2 || order[0] != 0 || order[1] != N) begin fails++; $display("FAIL rw_same_order: %0d done first=%0d, expected read(0) then write(4)", order.size(), order[0]); end
        tests++;
        if (rd[0] !== 8'h5A || mem[8'h41] !== 8'h99) begin fails++; $display("FAIL rw_same_data: read %h mem %h expected 5a 99", rd[0], mem[8'h41]); end
    endtask

    task automatic test_early_drop();
        int n = 0;
        rd_lat = 3;
        mem[8'h55] = 8'h3C;
        ra[1] = 8'h55;
        rv[1] = 1'b1;
        tick();
        tick();
        tests++;
        if (mrv !== 1'b1) begin fails++; $display("FAIL early_drop_inflight: mem_read_valid=%b expected 1", mrv); end
        rv[1] = 1'b0;
        while (!rr[1] && n < 50) begin tick(); n++; end
        tests++;
        if (rr[1] !== 1'b1 || rd[1] !== 8'h3C) begin fails++; $display("FAIL early_drop_complete: ready=%b data=%h expected 1 3c", rr[1], rd[1]); end
        tick();
        tests++;
        if (rr !== '0) begin fails++; $display("FAIL early_drop_pulse: got %b expected 0000", rr); end
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        rd_lat = -1;
        ra[2] = 8'h10;
        rv[2] = 1'b1;
        tick();
        tick();
        tests++;
        if (mrv !== 1'b1) begin fails++; $display("FAIL reset_mid_inflight: mem_read_valid=%b expected 1", mrv); end
        reset = 1'b1;
        #1;
        tests++;
        if (mrv !== 1'b0 || rd !== '0) begin fails++; $display("FAIL reset_mid_async: valid=%b data=%h expected 0 0", mrv, rd); end
        rv[2] = 1'b0;
        mrr = 1'b0;
        rd_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rr !== '0 || wr !== '0) stray++;
        end
        reset = 1'b0;
        tick();
        if (rr !== '0) stray++;
        tests++;
        if (stray != 0) begin fails++; $display("FAIL reset_mid_ready: %0d cycles with a ready pulse, expected 0", stray); end
        rd_lat = 0;
        ra[0] = 8'h01;
        ra[3] = 8'h03;
        rv = 4'b1001;
        collect();
        tests++;
        if (order.size() != 2 || order[0] != 0 || order[1] != 3) begin fails++; $display("FAIL reset_mid_rr: %0d grants first=%0d, expected 0 then 3", order.size(), order[0]); end
    endtask

`ifdef MEM_ARB_WATCHDOG_EN
    task automatic test_watchdog();
        int n;
        do_reset();
        rd_lat = -1;
        mem[8'h10] = 8'hA5;
        ra[0] = 8'h10;
        rv[0] = 1'b1;
        wait_ready(0, 1'b0, n);
        tests++;
        if (n !== 9) begin fails++; $display("FAIL wd_latency: ready after %0d negedges, expected 9", n); end
        tests++;
        if (rd[0] !== 8'h00 || mrv !== 1'b0) begin fails++; $display("FAIL wd_data: data=%h valid=%b expected 00 0", rd[0], mrv); end
        tests++;
        if (timeout_err !== 1'b1) begin fails++; $display("FAIL wd_flag: got %b expected 1", timeout_err); end
        rv[0] = 1'b0;
        tick();
        rd_lat = 0;
        rv[0] = 1'b1;
        collect();
        tests++;
        if (timeout_err !== 1'b1 || rd[0] !== 8'hA5) begin fails++; $display("FAIL wd_sticky: flag=%b data=%h expected 1 a5", timeout_err, rd[0]); end
    endtask
`endif

    // Model: grant = first pending consumer at or after the model's pointer, read before write.
    task automatic test_random();
        int ptr_m = 0, exp_c = 0, done = 0, g, fair_errs = 0;
        bit exp_act = 1'b0, exp_wr = 1'b0, prev_mv = 1'b0, mv;
        logic [7:0] exp_a = '0, exp_d = '0;
        logic [N-1:0] drop_r, drop_w;
        logic [2*N-1:0] rdy, want;
        int waited [N];
        do_reset();
        for (int a = 0; a < 256; a++) ref_mem[a] = mem[a];
        for (int i = 0; i < N; i++) waited[i] = 0;
        for (int t = 0; t < 3400; t++) begin
            tick();
            drop_r = '0;
            drop_w = '0;
            mv = mrv | mwv;
            tests++;
            if (mrv && mwv) begin fails++; $display("FAIL rand_mem_valid: read=%b write=%b, at most one allowed", mrv, mwv); end
            if (mv && !prev_mv) begin
                g = -1;
                for (int k = 0; k < N; k++)
                    if (g < 0 && (rv[(ptr_m + k) % N] || wv[(ptr_m + k) % N])) g = (ptr_m + k) % N;
                tests++;
                if (g < 0) begin
                    fails++;
                    $display("FAIL rand_grant: grant with no pending request");
                end else begin
                    exp_c = g;
                    exp_wr = !rv[g];
                    exp_a = exp_wr ? wa[g] : ra[g];
                    exp_d = wd[g];
                    if (mrv !== !exp_wr || (exp_wr ? (mwa !== exp_a || mwd !== exp_d) : (mra !== exp_a))) begin
                        fails++;
                        $display("FAIL rand_grant: rd=%b raddr=%h waddr=%h wdata=%h, expected consumer %0d write=%b addr=%h data=%h", mrv, mra, mwa, mwd, g, exp_wr, exp_a, exp_d);
                    end
                    for (int i = 0; i < N; i++) begin
                        waited[i] = (i == g || !(rv[i] || wv[i])) ? 0 : waited[i] + 1;
                        if (waited[i] > N - 1) fair_errs++;
                    end
                    ptr_m = (g + 1) % N;
                    exp_act = 1'b1;
                    rd_lat = $urandom_range(0, 3);
                    wr_lat = $urandom_range(0, 3);
                end
            end
            prev_mv = mv;
            rdy = {wr, rr};
            if (rdy != '0) begin
                want = '0;
                if (exp_act) want[exp_wr ? exp_c + N : exp_c] = 1'b1;
                tests++;
                if (rdy !== want) begin
                    fails++;
                    $display("FAIL rand_ready: got {write,read}=%b expected %b", rdy, want);
                end else if (!exp_wr) begin
                    tests++;
                    if (rd[exp_c] !== ref_mem[exp_a]) begin fails++; $display("FAIL rand_read_data: consumer %0d addr %h got %h expected %h", exp_c, exp_a, rd[exp_c], ref_mem[exp_a]); end
                end
                if (exp_act) begin
                    if (exp_wr) begin
                        ref_mem[exp_a] = exp_d;
                        wv[exp_c] = 1'b0;
                        drop_w[exp_c] = 1'b1;
                    end else begin
                        rv[exp_c] = 1'b0;
                        drop_r[exp_c] = 1'b1;
                    end
                    done++;
                end
                exp_act = 1'b0;
            end
            if (t < 3000)
                for (int i = 0; i < N; i++) begin
                    if (!rv[i] && !drop_r[i] && $urandom_range(0, 3) == 0) begin
                        ra[i] = 8'($urandom_range(0, 15));
                        rv[i] = 1'b1;
                    end
                    if (!wv[i] && !drop_w[i] && $urandom_range(0, 5) == 0) begin
                        wa[i] = 8'($urandom_range(0, 15));
                        wd[i] = 8'($urandom);
                        wv[i] = 1'b1;
                    end
                end
        end
        tests++;
        if (fair_errs != 0) begin fails++; $display("FAIL rand_fairness: %0d waits beyond %0d grants, expected 0", fair_errs, N - 1); end
        tests++;
        if ((rv | wv) !== '0 || done < 100) begin fails++; $display("FAIL rand_drain: pending r=%b w=%b done=%0d, expected none pending and >=100 done", rv, wv, done); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rv = '0;
        wv = '0;
        ra = '0;
        wa = '0;
        wd = '0;
        mrr = 1'b0;
        mwr = 1'b0;
        mrd = '0;
        rd_lat = 0;
        wr_lat = 0;
        rd_cnt = 0;
        wr_cnt = 0;
        for (int a = 0; a < 256; a++) mem[a] = 8'(a * 7 + 3);
        test_reset();
        test_single_read();
        test_contention();
        test_write();
        test_read_write_same();
        test_early_drop();
        test_reset_mid();
`ifdef MEM_ARB_WATCHDOG_EN
        test_watchdog();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
